// File: rtl/approx_seq_mul8.sv
// approx_seq_mul8: 8x8 unsigned shift-and-add multiplier. The partial-product
// accumulator uses an adder whose low APPROX_BITS carries are approximate
// (generate-only, ignoring the incoming carry). The upper bits ripple exactly.
// The handshake is valid/ready on both sides and one operation is in flight
// at a time. The FSM walks IDLE -> RUN (8 cycles) -> DONE.
module approx_seq_mul8 #(
  parameter int APPROX_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplr;
  logic [2:0]  count;

  // 16-bit ripple adder. For a bit below APPROX_BITS, the carry out is only x&y,
  // so a carry entering that bit does not travel further. Bits above it use
  // the exact majority carry. The carry out of bit 15 is dropped, so the sum
  // wraps modulo 2^16.
  function automatic logic [15:0] approx_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] s;
    logic        c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      if (i < APPROX_BITS) c = x[i] & y[i];
      else                 c = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return s;
  endfunction

  // State register. The synchronous reset overrides every handshake input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together at the edge, and no read depends on block order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs. in_ready and out_valid come from the state only.
  always_comb begin
    // NOTE: every output of this block gets a default first. This way no path
    // leaves a signal unassigned, and no latch is inferred.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (count == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Load the operands on acceptance, then do one shift-and-add
  // step per RUN cycle. In DONE nothing changes, so product holds under
  // backpressure. The operand inputs are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= {8'h00, a};
            mplr  <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          if (mplr[0]) acc <= approx_add(acc, mcand);
          mcand <= {mcand[14:0], 1'b0};
          mplr  <= {1'b0, mplr[7:1]};
          count <= count + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // The result register feeds the output directly. It is only meaningful while out_valid=1.
  assign product = acc;

endmodule

// File: tb/tb_approx_seq_mul8.sv
// tb_approx_seq_mul8: four multiplier instances run in lockstep from shared
// stimulus, one for each APPROX_BITS in {0,4,8,16}. A bench-side arithmetic
// model of the approximate adder gives each expected product. Inputs are
// driven and outputs sampled on the falling edge.
module tb_approx_seq_mul8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_ready;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [15:0] pr [4];

  int n_checks = 0;
  int n_errors = 0;
  int ab_tab [4] = '{0, 4, 8, 16};

  always #5 clk = ~clk;

  approx_seq_mul8 #(.APPROX_BITS(0)) u_ab0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready), .product(pr[0]));
  approx_seq_mul8 #(.APPROX_BITS(4)) u_ab4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready), .product(pr[1]));
  approx_seq_mul8 #(.APPROX_BITS(8)) u_ab8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(out_ready), .product(pr[2]));
  approx_seq_mul8 #(.APPROX_BITS(16)) u_ab16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
    .out_valid(ov[3]), .out_ready(out_ready), .product(pr[3]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference adder written in word terms. The low field is XOR plus the
  // per-bit generate moved up one place. The high field is an ordinary
  // addition, plus the generate carry out of the top approximate bit.
  function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y, input int ab);
    int unsigned xi, yi, mask, low, high, cin, r;
    xi   = x;
    yi   = y;
    mask = (ab >= 16) ? 32'hFFFF : ((32'd1 << ab) - 1);
    low  = ((xi ^ yi) ^ ((xi & yi) << 1)) & mask;
    cin  = (ab > 0) ? (((xi >> (ab - 1)) & (yi >> (ab - 1))) & 1) : 0;
    high = (ab >= 16) ? 0 : ((((xi >> ab) + (yi >> ab) + cin) << ab) & 32'hFFFF);
    r    = low | high;
    return r[15:0];
  endfunction

  function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y, input int ab);
    logic [15:0] acc;
    logic [15:0] pp;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      pp = 16'(x) << i;
      if (y[i]) acc = model_add(acc, pp, ab);
    end
    return acc;
  endfunction

  // Start one operation from a falling edge in IDLE. Measure latency in
  // edges, counting the accepting edge as the first edge. Check all four
  // products. Hold the result under backpressure for 'stall' cycles, then
  // complete the handshake. Operand inputs carry noise while busy.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input int stall,
                       output logic [15:0] res0, output logic [15:0] res8);
    int   n;
    logic busy_ready;
    logic [63:0] held;
    check("in_ready_idle", {60'd0, ir}, 64'hF);
    in_valid  = 1'b1;
    a         = oa;
    b         = ob;
    out_ready = 1'b0;
    @(posedge clk);
    n = 1;
    busy_ready = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a        = 8'($urandom);
      b        = 8'($urandom);
      if (ov[0]) break;
      busy_ready = busy_ready | (|ir) | (|ov);
      @(posedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd9);
    check("in_ready_busy", {63'd0, busy_ready}, 64'd0);
    check("out_valid_all", {60'd0, ov}, 64'hF);
    for (int k = 0; k < 4; k++)
      check($sformatf("product_ab%0d a=%0h b=%0h", ab_tab[k], oa, ob), 64'(pr[k]), 64'(model_mul(oa, ob, ab_tab[k])));
    res0 = pr[0];
    res8 = pr[2];
    held = {pr[3], pr[2], pr[1], pr[0]};
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a        = 8'($urandom);
      b        = 8'($urandom);
      check("stall_valid", {60'd0, ov, ir}, 64'hF0);
      check("stall_product", {pr[3], pr[2], pr[1], pr[0]}, held);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("after_handshake", {56'd0, ov, ir}, 64'h0F);
  endtask

  initial begin
    logic [15:0] r0, r8;
    int stall;
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 8'hFF;
    b         = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {ov, ir, pr[0], pr[1], pr[2], pr[3]}, {4'h0, 4'hF, 64'd0});
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Directed cases, each checked against literal products.
    do_op(8'd3, 8'd3, 0, r0, r8);
    check("ab8_3x3", 64'(r8), 64'h0001);
    check("ab0_3x3", 64'(r0), 64'h0009);
    do_op(8'hFF, 8'hFF, 0, r0, r8);
    check("ab0_ffxff", 64'(r0), 64'hFE01);
    do_op(8'hFF, 8'h01, 0, r0, r8);
    check("ab8_ffx01", 64'(r8), 64'h00FF);
    do_op(8'h00, 8'hFF, 0, r0, r8);
    check("ab8_00xff", 64'(r8), 64'h0000);

    // Backpressure: hold the result in DONE for 5 cycles.
    do_op(8'hA5, 8'h3C, 5, r0, r8);

    // Reset while RUN has count=4. After acceptance, 4 more edges give count=4.
    in_valid = 1'b1;
    a        = 8'd9;
    b        = 8'd9;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset", {ov, ir, pr[0], pr[1], pr[2], pr[3]}, {4'h0, 4'hF, 64'd0});
    reset = 1'b0;
    do_op(8'd2, 8'd5, 0, r0, r8);
    check("ab8_2x5_after_reset", 64'(r8), 64'h000A);

    // Random regression with random result stalls.
    for (int t = 0; t < 2000; t++) begin
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(8'($urandom), 8'($urandom), stall, r0, r8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
